ram_arbiter: RTL and testbench

//   Sequences the 16x8 RAM and shares it between the CPU core and the program loader.

---
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: sequences a shared RAM between the CPU core and the program loader.
// Optional RAM_ARB_ROUND_ROBIN_EN: alternating tie-break instead of fixed loader priority.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic              ram_oe_n,
  inout  wire  [DATA_W-1:0] ram_data,
  output logic              busy,
  output logic              owner
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
  logic                grant_ldr;
  logic                drive_bus;

  always_comb begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
    // On a tie the requester that was not served last wins; owner resets to CPU.
    if (cpu_req && ldr_req) begin
      grant_ldr = ~owner_q;
    end else begin
      grant_ldr = ldr_req;
    end
`else
    grant_ldr = ldr_req;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      owner_q     <= 1'b0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      owner_q     <= owner_d;
      cpu_rdata_q <= cpu_rdata_d;
      ldr_rdata_q <= ldr_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    owner_d     = owner_q;
    cpu_rdata_d = cpu_rdata_q;
    ldr_rdata_d = ldr_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_req || ldr_req) begin
          state_d = StAccess;
          owner_d = grant_ldr;
          we_d    = grant_ldr ? ldr_we    : cpu_we;
          addr_d  = grant_ldr ? ldr_addr  : cpu_addr;
          wdata_d = grant_ldr ? ldr_wdata : cpu_wdata;
        end
      end
      StAccess: begin
        state_d = StDone;
        if (!we_q) begin
          if (owner_q) begin
            ldr_rdata_d = ram_data;
          end else begin
            cpu_rdata_d = ram_data;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ram_we    = (state_q == StAccess) &&  we_q;
    ram_oe_n  = !((state_q == StAccess) && !we_q);
    drive_bus = (state_q == StAccess) &&  we_q;
    cpu_ack   = (state_q == StDone) && !owner_q;
    ldr_ack   = (state_q == StDone) &&  owner_q;
    busy      = (state_q != StIdle);
  end

  // Address stays on the last latched value outside ACCESS.
  assign ram_addr  = addr_q;
  assign ram_data  = drive_bus ? wdata_q : {DATA_W{1'bz}};
  assign owner     = owner_q;
  assign cpu_rdata = cpu_rdata_q;
  assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed accesses, expected grants queued by the driver and checked by
// a monitor against the RAM bus and ack pulses. Honours RAM_ARB_ROUND_ROBIN_EN when defined.
module tb_ram_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [3:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       ldr_req = 1'b0, ldr_we = 1'b0;
  logic [3:0] ldr_addr = '0;
  logic [7:0] ldr_wdata = '0;
  logic       ldr_ack;
  logic [7:0] ldr_rdata;
  logic [3:0] ram_addr;
  logic       ram_we, ram_oe_n, busy, owner;
  wire  [7:0] ram_data;

  logic [7:0] mem [16];

  typedef struct packed {
    logic       port;  // 0 = CPU, 1 = loader
    logic       we;
    logic [3:0] addr;
    logic [7:0] data;  // write data, or expected read data
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ram_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_ack   (cpu_ack),
    .cpu_rdata (cpu_rdata),
    .ldr_req   (ldr_req),
    .ldr_we    (ldr_we),
    .ldr_addr  (ldr_addr),
    .ldr_wdata (ldr_wdata),
    .ldr_ack   (ldr_ack),
    .ldr_rdata (ldr_rdata),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_oe_n  (ram_oe_n),
    .ram_data  (ram_data),
    .busy      (busy),
    .owner     (owner)
  );

  always #5 clk = ~clk;

  // RAM device: drives the bus while oe_n is low, captures on posedge when we is high.
  assign ram_data = ram_oe_n ? 8'bz : mem[ram_addr];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_data;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Monitor
  logic cpu_ack_d = 1'b0, ldr_ack_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("we_oe_overlap", 32'(ram_we & ~ram_oe_n), 0);
      check("ack_onehot", 32'(cpu_ack & ldr_ack), 0);
      check("ack_width", 32'((cpu_ack & cpu_ack_d) | (ldr_ack & ldr_ack_d)), 0);
      if (ram_we || !ram_oe_n) begin
        if (exp_q.size() == 0) begin
          check("access_unexpected", 1, 0);
        end else begin
          e = exp_q[0];
          check("access_we", 32'(ram_we), 32'(e.we));
          check("access_addr", 32'(ram_addr), 32'(e.addr));
          if (ram_we) check("write_bus", 32'(ram_data), 32'(e.data));
        end
      end
      if (cpu_ack || ldr_ack) begin
        if (exp_q.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", 32'(ldr_ack), 32'(e.port));
          check("owner", 32'(owner), 32'(e.port));
          if (!e.we) check("rdata", 32'(e.port ? ldr_rdata : cpu_rdata), 32'(e.data));
        end
      end
    end
    cpu_ack_d = cpu_ack;
    ldr_ack_d = ldr_ack;
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    exp_q.delete();
    #1 rst = 1'b0;
  endtask

  task automatic set_port(input bit port, input bit req, input bit we, input logic [3:0] addr,
                          input logic [7:0] data);
    if (port) begin
      ldr_req = req; ldr_we = we; ldr_addr = addr; ldr_wdata = data;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = data;
    end
  endtask

  // One complete access from an idle arbiter; returns once the ack has been seen.
  task automatic do_access(input bit port, input bit we, input logic [3:0] addr,
                           input logic [7:0] data, input bit chk_lat);
    int  n;
    logic ack;
    exp_q.push_back(exp_t'{port, we, addr, data});
    @(posedge clk);
    #1 set_port(port, 1'b1, we, addr, data);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      ack = port ? ldr_ack : cpu_ack;
    end while (!ack && n < 10);
    if (!ack) begin
      check("ack_timeout", 0, 1);
      void'(exp_q.pop_front());
    end else if (chk_lat) begin
      // Idle cycle, ACCESS, then DONE: ack on the third falling edge.
      check("latency", 32'(n), 3);
    end
    set_port(port, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    int   n;
    int   acks;
    logic [3:0] a;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    do_reset();
    @(negedge clk);
    check("rst_ram_we", 32'(ram_we), 0);
    check("rst_ram_oe_n", 32'(ram_oe_n), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_owner", 32'(owner), 0);
    check("rst_cpu_ack", 32'(cpu_ack), 0);
    check("rst_ldr_ack", 32'(ldr_ack), 0);
    check("rst_ram_addr", 32'(ram_addr), 0);
    check("rst_cpu_rdata", 32'(cpu_rdata), 0);
    check("rst_ldr_rdata", 32'(ldr_rdata), 0);

    // Loader write, then CPU read of the same word.
    do_access(1'b1, 1'b1, 4'd3, 8'hA5, 1'b1);
    do_access(1'b0, 1'b0, 4'd3, 8'hA5, 1'b1);
    check("t1_cpu_rdata", 32'(cpu_rdata), 32'hA5);

    // CPU fills the RAM, loader reads it back from the top down.
    for (int i = 0; i < 16; i++) begin
      a = 4'(i);
      do_access(1'b0, 1'b1, a, {4'h0, a} ^ 8'h5A, 1'b0);
    end
    for (int i = 15; i >= 0; i--) begin
      a = 4'(i);
      do_access(1'b1, 1'b0, a, {4'h0, a} ^ 8'h5A, 1'b0);
    end
    check("t2_ldr_rdata_last", 32'(ldr_rdata), 32'h5A);
    check("t2_cpu_rdata_hold", 32'(cpu_rdata), 32'hA5);

    // Both requesters held from the same idle cycle for four grants.
    do_reset();
`ifdef RAM_ARB_ROUND_ROBIN_EN
    exp_q.push_back(exp_t'{1'b1, 1'b1, 4'd8, 8'h11});
    exp_q.push_back(exp_t'{1'b0, 1'b1, 4'd9, 8'h22});
    exp_q.push_back(exp_t'{1'b1, 1'b1, 4'd8, 8'h11});
    exp_q.push_back(exp_t'{1'b0, 1'b1, 4'd9, 8'h22});
`else
    for (int i = 0; i < 4; i++) exp_q.push_back(exp_t'{1'b1, 1'b1, 4'd8, 8'h11});
`endif
    @(posedge clk);
    #1;
    set_port(1'b1, 1'b1, 1'b1, 4'd8, 8'h11);
    set_port(1'b0, 1'b1, 1'b1, 4'd9, 8'h22);
    acks = 0;
    n = 0;
    while (acks < 4 && n < 40) begin
      @(negedge clk);
      n++;
      if (cpu_ack || ldr_ack) acks++;
    end
    check("t3_ack_count", 32'(acks), 4);
    set_port(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    set_port(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(negedge clk);
    exp_q.delete();

    // Reset during a write ACCESS; the held request then completes normally.
    exp_q.push_back(exp_t'{1'b0, 1'b1, 4'd5, 8'h77});
    @(posedge clk);
    #1 set_port(1'b0, 1'b1, 1'b1, 4'd5, 8'h77);
    @(negedge clk);
    @(negedge clk);
    check("t4_in_access", 32'(ram_we), 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t4_rst_ram_we", 32'(ram_we), 0);
    check("t4_rst_oe_n", 32'(ram_oe_n), 1);
    check("t4_rst_busy", 32'(busy), 0);
    check("t4_rst_no_ack", 32'(cpu_ack), 0);
    n = 0;
    while (!cpu_ack && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("t4_reissue_ack", 32'(cpu_ack), 1);
    if (!cpu_ack) exp_q.delete();
    set_port(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    do_access(1'b1, 1'b0, 4'd5, 8'h77, 1'b1);
    check("t4_readback", 32'(ldr_rdata), 32'h77);

    repeat (3) @(negedge clk);
    check("end_queue_empty", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule
